// File: rtl/sc_pkg.sv
// Shared types and constants for the single-cycle MIPS32 instruction fetch unit.
package sc_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StValid = 2'd2,
        StFault = 2'd3
    } sc_state_e;

    localparam logic [1:0] PCS_SEQ = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_JR  = 2'b10;
    localparam logic [1:0] PCS_J   = 2'b11;

    // Branch displacement: sign-extended word offset converted to a byte offset.
    function automatic logic [31:0] sc_br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/sc_npc.sv
// Next-PC selection for the fetch unit; purely combinational.
module sc_npc
    import sc_pkg::*;
(
    input  logic [31:0] pc4,
    input  logic [31:0] inst,
    input  logic [31:0] ra,
    input  logic [1:0]  pcsource,
    output logic [31:0] npc,
    output logic        misaligned
);

    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic        w_unused;

    assign w_br_target = pc4 + sc_br_offset(inst[15:0]);
    assign w_j_target  = {pc4[31:28], inst[25:0], 2'b00};
    // Opcode bits are decoded by the control unit, not here.
    assign w_unused    = ^inst[31:26];

    always_comb begin
        npc = pc4;
        unique case (pcsource)
            PCS_SEQ: npc = pc4;
            PCS_BR:  npc = w_br_target;
            PCS_JR:  npc = ra;
            PCS_J:   npc = w_j_target;
            default: npc = pc4;
        endcase
    end

    assign misaligned = (npc[1:0] != 2'b00);

endmodule

// File: rtl/sc_ifu.sv
// Instruction fetch unit: PC, imem req/ack handshake, one-deep instruction hold,
// next-PC update on commit and sticky misaligned-target trap.
module sc_ifu
    import sc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic [1:0]  pcsource,
    input  logic [31:0] ra,
    output logic        fault,
    output logic [31:0] icount
);

    sc_state_e   r_state;
    sc_state_e   w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_fault;
    logic [31:0] r_icount;
    logic [31:0] w_pc4;
    logic [31:0] w_npc;
    logic        w_misaligned;
    logic        w_fill;
    logic        w_commit;

    assign w_pc4    = r_pc + 32'd4;
    assign w_fill   = (r_state == StFetch) && imem_ack;
    assign w_commit = (r_state == StValid) && inst_ready;

    sc_npc u_npc (
        .pc4        (w_pc4),
        .inst       (r_inst),
        .ra         (ra),
        .pcsource   (pcsource),
        .npc        (w_npc),
        .misaligned (w_misaligned)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  w_state_next = StFetch;
            StFetch: if (imem_ack) w_state_next = StValid;
            StValid: if (inst_ready) w_state_next = w_misaligned ? StFault : StFetch;
            StFault: w_state_next = StFault;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        unique case (r_state)
            StFetch: imem_req   = 1'b1;
            StValid: inst_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pc <= RESET_PC;
        end else if (w_commit) begin
            // A faulting target is still loaded so the trap address is observable.
            r_pc <= w_npc;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_inst <= 32'd0;
        end else if (w_fill) begin
            r_inst <= imem_rdata;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_fault <= 1'b0;
        end else if (w_commit && w_misaligned) begin
            r_fault <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_icount <= 32'd0;
        end else if (w_commit) begin
            r_icount <= r_icount + 32'd1;
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign pc4       = w_pc4;
    assign inst      = r_inst;
    assign fault     = r_fault;
    assign icount    = r_icount;

endmodule

// File: tb/tb_sc_ifu.sv
// Directed bench for sc_ifu: memory responder with expected-fetch/expected-issue scoreboards.
module tb_sc_ifu;
    import sc_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_t;

    logic        clock;
    logic        resetn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        inst_valid;
    logic        inst_ready;
    logic [1:0]  pcsource;
    logic [31:0] ra;
    logic        fault;
    logic [31:0] icount;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          c0;
    logic [31:0] exp_addr_q[$];
    fetch_t      fetch_q[$];
    logic [31:0] m_icount;

    sc_ifu #(.RESET_PC(RST_PC)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .pc         (pc),
        .pc4        (pc4),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .pcsource   (pcsource),
        .ra         (ra),
        .fault      (fault),
        .icount     (icount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_npc(input logic [31:0] p, input logic [31:0] iw,
                                              input logic [1:0] pcs, input logic [31:0] rv);
        logic [31:0]        p4;
        logic signed [31:0] off;
        p4  = p + 32'd4;
        off = {{16{iw[15]}}, iw[15:0]};
        case (pcs)
            2'b00:   return p4;
            2'b01:   return p4 + 32'(off * 4);
            2'b10:   return rv;
            default: return {p4[31:28], iw[25:0], 2'b00};
        endcase
    endfunction

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (imem_req !== 1'b1) chk("req_timeout", {31'd0, imem_req}, 32'd1);
    endtask

    // One full instruction: fetch with wait states, hold with stalls, commit.
    task automatic do_inst(input logic [31:0] word, input int waits, input int stalls,
                           input logic [1:0] pcs, input logic [31:0] rav, input logic exp_fault);
        logic [31:0] addr;
        logic [31:0] npc;
        fetch_t      f;
        wait_req();
        addr = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 32'hDEAD_BEEF;
        chk("fetch_addr", imem_addr, addr);
        for (int i = 0; i < waits; i++) begin
            imem_ack = 1'b0;
            @(negedge clock);
            chk("addr_stable", imem_addr, addr);
            chk("req_in_wait", {31'd0, imem_req}, 32'd1);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        fetch_q.push_back('{pc: addr, inst: word});
        @(negedge clock);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        chk("inst_valid", {31'd0, inst_valid}, 32'd1);
        f = fetch_q.pop_front();
        chk("inst", inst, f.inst);
        chk("pc", pc, f.pc);
        chk("pc4", pc4, f.pc + 32'd4);
        for (int i = 0; i < stalls; i++) begin
            inst_ready = 1'b0;
            pcsource   = 2'($urandom);
            ra         = $urandom;
            imem_ack   = 1'b1;
            imem_rdata = $urandom;
            @(negedge clock);
            chk("stall_inst", inst, f.inst);
            chk("stall_pc", pc, f.pc);
            chk("stall_valid", {31'd0, inst_valid}, 32'd1);
        end
        imem_ack   = 1'b0;
        inst_ready = 1'b1;
        pcsource   = pcs;
        ra         = rav;
        npc        = model_npc(f.pc, f.inst, pcs, rav);
        m_icount   = m_icount + 32'd1;
        if (!exp_fault) exp_addr_q.push_back(npc);
        @(negedge clock);
        inst_ready = 1'b0;
        chk("icount", icount, m_icount);
        chk("pc_after_commit", pc, npc);
        chk("fault", {31'd0, fault}, {31'd0, exp_fault});
        chk("req_after_commit", {31'd0, imem_req}, {31'd0, ~exp_fault});
    endtask

    task automatic release_reset();
        @(negedge clock);
        resetn = 1'b1;
        chk("req_idle", {31'd0, imem_req}, 32'd0);
        @(negedge clock);
        chk("req_first", {31'd0, imem_req}, 32'd1);
        exp_addr_q.delete();
        fetch_q.delete();
        exp_addr_q.push_back(RST_PC);
        m_icount = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn     = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        inst_ready = 1'b0;
        pcsource   = 2'b00;
        ra         = 32'd0;
        #23;
        chk("rst_pc", pc, RST_PC);
        chk("rst_inst", inst, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_icount", icount, 32'd0);

        release_reset();
        do_inst(32'h2008_0005, 0, 0, PCS_SEQ, 32'd0, 1'b0);

        c0 = cyc;
        do_inst(32'h0000_0000, 3, 2, PCS_SEQ, 32'd0, 1'b0);
        chk("cycles_per_inst", 32'(cyc - c0), 32'd7);

        do_inst(32'h0100_0008, 0, 0, PCS_JR, 32'h0000_0200, 1'b0);
        do_inst(32'h1000_FFFE, 0, 0, PCS_BR, 32'd0, 1'b0);
        do_inst(32'h0100_0008, 1, 0, PCS_JR, 32'hF000_0010, 1'b0);
        do_inst(32'h0800_0040, 0, 1, PCS_J, 32'd0, 1'b0);

        force dut.r_icount = 32'hFFFF_FFFF;
        #1;
        release dut.r_icount;
        m_icount = 32'hFFFF_FFFF;
        do_inst(32'h0100_0008, 0, 0, PCS_JR, 32'h0000_0104, 1'b0);

        do_inst(32'h0100_0008, 0, 0, PCS_JR, 32'h0000_0102, 1'b1);
        for (int i = 0; i < 4; i++) begin
            imem_ack   = 1'b1;
            inst_ready = 1'b1;
            @(negedge clock);
            chk("fault_req", {31'd0, imem_req}, 32'd0);
            chk("fault_valid", {31'd0, inst_valid}, 32'd0);
            chk("fault_sticky", {31'd0, fault}, 32'd1);
            chk("fault_pc", pc, 32'h0000_0102);
        end
        imem_ack   = 1'b0;
        inst_ready = 1'b0;

        resetn = 1'b0;
        #1;
        chk("rst2_fault", {31'd0, fault}, 32'd0);
        release_reset();
        do_inst(32'h2008_0005, 2, 0, PCS_SEQ, 32'd0, 1'b0);
        @(negedge clock);
        chk("mid_fetch_req", {31'd0, imem_req}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_req", {31'd0, imem_req}, 32'd0);
        chk("async_pc", pc, RST_PC);
        chk("async_icount", icount, 32'd0);
        chk("async_fault", {31'd0, fault}, 32'd0);
        chk("async_valid", {31'd0, inst_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
